// File: rtl/sc_pkg.sv
// ---------------------------------------------------------------------------
// sc_pkg -- shared definitions for the stochastic-computing datapath.
//
// Holds the stochastic stream length constant and the FSM state encoding
// used by the stochastic-to-binary decoder (and the matching converter).
// ---------------------------------------------------------------------------
package sc_pkg;

  // Binary width of stochastic values; a window carries 2**SC_LENGTH-1 bits.
  localparam int SC_LENGTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } sc_state_e;

endpackage : sc_pkg

// File: rtl/sc_window_counter.sv
// ---------------------------------------------------------------------------
// sc_window_counter -- counts qualified bits and ones within one window.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset, clears both counters
//   clear   in   clears both counters (start of a new window)
//   enable  in   consume bit_in this edge (qualified bit)
//   bit_in  in   stochastic bit to accumulate
//   ones    out  number of ones consumed so far in the window
//   last    out  the next qualified bit is the final bit of the window
// ---------------------------------------------------------------------------
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int WIDTH = SC_LENGTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             bit_in,
  output logic [WIDTH-1:0] ones,
  output logic             last
);

  // Index of the final qualified bit: 2**WIDTH-2 counted bits precede it.
  localparam logic [WIDTH-1:0] LAST_IDX = {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0] bit_cnt_reg;
  logic [WIDTH-1:0] ones_reg;

  // ones_reg can reach at most 2**WIDTH-1 (after the final bit), so it
  // never wraps within a window.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bit_cnt_reg <= '0;
      ones_reg    <= '0;
    end else if (enable) begin
      bit_cnt_reg <= bit_cnt_reg + 1'b1;
      ones_reg    <= ones_reg + {{(WIDTH-1){1'b0}}, bit_in};
    end
  end

  assign ones = ones_reg;
  assign last = (bit_cnt_reg == LAST_IDX);

endmodule : sc_window_counter

// File: rtl/sc_to_binary.sv
// ---------------------------------------------------------------------------
// sc_to_binary -- decodes a stochastic bitstream into a binary ones count.
//
// After a start request, 2**WIDTH-1 qualified bits (sc_valid=1) are
// accumulated; the ones count is then presented on bnum with out_valid until
// the consumer accepts it with out_ready.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   begin a window (only honoured when idle)
//   sc_bit     in   stochastic bit
//   sc_valid   in   sc_bit qualifier
//   bnum       out  decoded value, held until the next window completes
//   out_valid  out  bnum holds a result not yet accepted
//   out_ready  in   consumer accepts bnum
//   busy       out  window in progress or result pending
// ---------------------------------------------------------------------------
module sc_to_binary
  import sc_pkg::*;
#(
  parameter int WIDTH = SC_LENGTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sc_bit,
  input  logic             sc_valid,
  output logic [WIDTH-1:0] bnum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  sc_state_e        state_reg, state_next;
  logic [WIDTH-1:0] bnum_reg, bnum_next;
  logic             out_valid_reg, out_valid_next;

  logic             cnt_clear;
  logic             cnt_enable;
  logic [WIDTH-1:0] cnt_ones;
  logic             cnt_last;

  sc_window_counter #(
    .WIDTH (WIDTH)
  ) u_window_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .bit_in (sc_bit),
    .ones   (cnt_ones),
    .last   (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      bnum_reg      <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bnum_reg      <= bnum_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bnum_next      = bnum_reg;
    out_valid_next = out_valid_reg;
    cnt_clear      = 1'b0;
    cnt_enable     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          cnt_clear  = 1'b1;
          state_next = COUNT;
        end
      end

      COUNT: begin
        if (sc_valid) begin
          cnt_enable = 1'b1;
          // The final bit is folded in directly so the result is registered
          // on the same edge that consumes it.
          if (cnt_last) begin
            bnum_next      = cnt_ones + {{(WIDTH-1){1'b0}}, sc_bit};
            out_valid_next = 1'b1;
            state_next     = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
      end
    endcase
  end

  assign bnum      = bnum_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg == COUNT) || (state_reg == DONE);

endmodule : sc_to_binary
